// File: rtl/regfile_param_if.sv
// Decode/write-back side bundle of the parametrised register file.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] radd1;
  logic [ADDR_W-1:0] radd2;
  logic [DATA_W-1:0] dout1;
  logic [DATA_W-1:0] dout2;
  logic              rdy1;
  logic              rdy2;
  logic              wen;
  logic [ADDR_W-1:0] wadd;
  logic [DATA_W-1:0] wdi;
  logic              link_en;
  logic [DATA_W-1:0] link_wdi;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_add;
  logic              clr_req;
  logic              clr_busy;
  logic [ADDR_W-1:0] radd_debug;
  logic [DATA_W-1:0] dout_debug;

  modport master (
    output radd1, radd2, wen, wadd, wdi, link_en, link_wdi,
           claim_en, claim_add, clr_req, radd_debug,
    input  dout1, dout2, rdy1, rdy2, clr_busy, dout_debug
  );

  modport slave (
    input  radd1, radd2, wen, wadd, wdi, link_en, link_wdi,
           claim_en, claim_add, clr_req, radd_debug,
    output dout1, dout2, rdy1, rdy2, clr_busy, dout_debug
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised CPU register file: write-first bypass, pending-write scoreboard,
// optional hard-wired zero entry and a sequenced soft-clear to reset contents.
module regfile_param #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                ZERO_REG = 1,
  parameter int                GP_IDX   = 28,
  parameter logic [DATA_W-1:0] GP_INIT  = 32'h10008000,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h000000FF,
  parameter int                LINK_IDX = 31
) (
  input logic            clk,
  input logic            res,
  regfile_param_if.slave bus
);
  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_IDX);
  localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic              ZERO_ON  = (ZERO_REG != 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   w_idx_next;
  logic [DATA_W-1:0] r_mem      [DEPTH];
  logic [DATA_W-1:0] w_mem_next [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_next;
  logic              w_idle, w_wen_eff, w_link_eff, w_claim_eff, w_clr_start;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_rd_dbg;
  logic              w_rdy1, w_rdy2;
  logic [DATA_W-1:0] r_dout1, r_dout2, r_dout_dbg;
  logic              r_rdy1, r_rdy2, r_clr_busy;

  function automatic logic [DATA_W-1:0] reset_val(input int idx);
    if (idx == GP_IDX) begin
      return GP_INIT;
    end else if (idx == SP_IDX) begin
      return SP_INIT;
    end else begin
      return {DATA_W{1'b0}};
    end
  endfunction

  // Qualified request strobes; nothing from the pipeline is accepted during a sweep.
  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    w_wen_eff   = w_idle && bus.wen && !(ZERO_ON && (bus.wadd == ZERO_A));
    w_link_eff  = w_idle && bus.link_en && !(ZERO_ON && (LINK_A == ZERO_A));
    w_clr_start = w_idle && bus.clr_req;
    w_claim_eff = w_idle && !bus.clr_req && bus.claim_en &&
                  !(ZERO_ON && (bus.claim_add == ZERO_A));
  end

  // Soft-clear sequencer next state and sweep index.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          w_state_next = ST_CLEAR;
          w_idx_next   = {(ADDR_W + 1){1'b0}};
        end else begin
          w_state_next = ST_IDLE;
          w_idx_next   = r_idx;
        end
      end
      ST_CLEAR: begin
        w_idx_next = r_idx + IDX_ONE;
        if (r_idx == LAST_IDX) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_CLEAR;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = {(ADDR_W + 1){1'b0}};
      end
    endcase
  end

  // Post-edge array and scoreboard; link beats general write, claim beats write.
  always_comb begin
    w_pend_next = r_pend;
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_next[i] = r_mem[i];
      if (!w_idle) begin
        w_mem_next[i] = (r_idx[ADDR_W-1:0] == ADDR_W'(i)) ? reset_val(i) : r_mem[i];
      end else if (w_link_eff && (LINK_A == ADDR_W'(i))) begin
        w_mem_next[i] = bus.link_wdi;
      end else if (w_wen_eff && (bus.wadd == ADDR_W'(i))) begin
        w_mem_next[i] = bus.wdi;
      end else begin
        w_mem_next[i] = r_mem[i];
      end

      if (w_clr_start) begin
        w_pend_next[i] = 1'b0;
      end else if (w_claim_eff && (bus.claim_add == ADDR_W'(i))) begin
        w_pend_next[i] = 1'b1;
      end else if ((w_link_eff && (LINK_A == ADDR_W'(i))) ||
                   (w_wen_eff && (bus.wadd == ADDR_W'(i)))) begin
        w_pend_next[i] = 1'b0;
      end else begin
        w_pend_next[i] = r_pend[i];
      end
    end
  end

  // Read mux: write-first when idle, raw contents while sweeping.
  always_comb begin
    w_rd1    = w_idle ? w_mem_next[bus.radd1]      : r_mem[bus.radd1];
    w_rd2    = w_idle ? w_mem_next[bus.radd2]      : r_mem[bus.radd2];
    w_rd_dbg = w_idle ? w_mem_next[bus.radd_debug] : r_mem[bus.radd_debug];
    w_rdy1   = w_idle && !w_pend_next[bus.radd1];
    w_rdy2   = w_idle && !w_pend_next[bus.radd2];
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state    <= ST_IDLE;
      r_idx      <= {(ADDR_W + 1){1'b0}};
      r_clr_busy <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_clr_busy <= (w_state_next == ST_CLEAR);
    end
  end

  // Register array and pending scoreboard.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= reset_val(i);
      end
      r_pend <= {DEPTH{1'b0}};
    end else begin
      r_mem  <= w_mem_next;
      r_pend <= w_pend_next;
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_dout1    <= {DATA_W{1'b0}};
      r_dout2    <= {DATA_W{1'b0}};
      r_dout_dbg <= {DATA_W{1'b0}};
      r_rdy1     <= 1'b1;
      r_rdy2     <= 1'b1;
    end else begin
      r_dout1    <= w_rd1;
      r_dout2    <= w_rd2;
      r_dout_dbg <= w_rd_dbg;
      r_rdy1     <= w_rdy1;
      r_rdy2     <= w_rdy2;
    end
  end

  assign bus.dout1      = r_dout1;
  assign bus.dout2      = r_dout2;
  assign bus.dout_debug = r_dout_dbg;
  assign bus.rdy1       = r_rdy1;
  assign bus.rdy2       = r_rdy2;
  assign bus.clr_busy   = r_clr_busy;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table, soft-clear and
// reset-abort sequences, then random traffic against an array-level model.
module tb_regfile_param;
  logic clk = 1'b0;
  logic res = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_param dut (.clk(clk), .res(res), .bus(bus));

  // Model: plain register array plus a pending flag per entry.
  logic [31:0] m_mem  [32];
  logic        m_pend [32];
  bit          m_busy;
  int          m_idx;
  logic [31:0] e_d1, e_d2, e_dbg;
  logic        e_r1, e_r2, e_busy;

  typedef struct {
    logic        wen;
    logic [4:0]  wadd;
    logic [31:0] wdi;
    logic        link_en;
    logic [31:0] link_wdi;
    logic        claim_en;
    logic [4:0]  claim_add;
    logic [4:0]  ra1, ra2, rdbg;
    logic [31:0] e1, e2, edbg;
    logic        er1, er2;
  } vec_t;
  vec_t vecs [13];

  function automatic logic [31:0] rst_val(input int a);
    return (a == 28) ? 32'h10008000 : (a == 29) ? 32'h000000FF : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = rst_val(i);
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  task automatic idle_inputs();
    bus.wen = 1'b0; bus.wadd = 5'd0; bus.wdi = 32'h0;
    bus.link_en = 1'b0; bus.link_wdi = 32'h0;
    bus.claim_en = 1'b0; bus.claim_add = 5'd0; bus.clr_req = 1'b0;
    bus.radd1 = 5'd0; bus.radd2 = 5'd0; bus.radd_debug = 5'd0;
  endtask

  // Apply the present inputs to the model as one clock edge.
  task automatic model_eval();
    if (!m_busy) begin
      if (bus.wen && bus.wadd != 5'd0) begin
        m_mem[bus.wadd] = bus.wdi; m_pend[bus.wadd] = 1'b0;
      end
      if (bus.link_en) begin
        m_mem[31] = bus.link_wdi; m_pend[31] = 1'b0;
      end
      if (bus.claim_en && bus.claim_add != 5'd0) m_pend[bus.claim_add] = 1'b1;
      if (bus.clr_req) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_busy = 1'b1;
        m_idx  = 0;
      end
      e_d1 = m_mem[bus.radd1]; e_d2 = m_mem[bus.radd2]; e_dbg = m_mem[bus.radd_debug];
      e_r1 = !m_pend[bus.radd1]; e_r2 = !m_pend[bus.radd2];
    end else begin
      e_d1 = m_mem[bus.radd1]; e_d2 = m_mem[bus.radd2]; e_dbg = m_mem[bus.radd_debug];
      e_r1 = 1'b0; e_r2 = 1'b0;
      m_mem[m_idx] = rst_val(m_idx);
      m_idx++;
      if (m_idx == 32) m_busy = 1'b0;
    end
    e_busy = m_busy;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    chk("dout1", bus.dout1, e_d1);
    chk("dout2", bus.dout2, e_d2);
    chk("dout_debug", bus.dout_debug, e_dbg);
    chk("rdy1", bus.rdy1, e_r1);
    chk("rdy2", bus.rdy2, e_r2);
    chk("clr_busy", bus.clr_busy, e_busy);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dout1"}, bus.dout1, 32'h0);
    chk({tag, "_dout2"}, bus.dout2, 32'h0);
    chk({tag, "_dbg"}, bus.dout_debug, 32'h0);
    chk({tag, "_rdy1"}, bus.rdy1, 1'b1);
    chk({tag, "_rdy2"}, bus.rdy2, 1'b1);
    chk({tag, "_busy"}, bus.clr_busy, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    // wen wadd wdi link link_wdi claim cadd ra1 ra2 rdbg e1 e2 edbg er1 er2
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd28, 5'd29, 5'd5,  32'h10008000, 32'h000000FF, 32'h0,        1'b1, 1'b1};
    vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 5'd0,  5'd3,  5'd28, 5'd3,  32'hDEADBEEF, 32'h10008000, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  5'd29, 32'hDEADBEEF, 32'hDEADBEEF, 32'h000000FF, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
    vecs[5]  = '{1'b1, 5'd31, 32'hAAAA,     1'b1, 32'h00400008, 1'b0, 5'd0,  5'd31, 5'd3,  5'd31, 32'h00400008, 32'hDEADBEEF, 32'h00400008, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd3,  5'd31, 5'd31, 32'hDEADBEEF, 32'h00400008, 32'h00400008, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 5'd7,  5'd7,  5'd6,  5'd7,  32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  5'd7,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd7,  32'h55,       1'b0, 32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  5'd7,  32'h55,       32'hDEADBEEF, 32'h55,       1'b1, 1'b1};
    vecs[10] = '{1'b1, 5'd7,  32'h66,       1'b0, 32'h0,        1'b1, 5'd7,  5'd7,  5'd7,  5'd7,  32'h66,       32'h66,       32'h66,       1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h12345678, 1'b1, 5'd31, 5'd31, 5'd7,  5'd31, 32'h12345678, 32'h66,       32'h12345678, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'd31, 32'hABCD,     1'b0, 32'h0,        1'b1, 5'd0,  5'd0,  5'd31, 5'd31, 32'h0,        32'hABCD,     32'hABCD,     1'b1, 1'b1};

    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    res = 1'b0;

    for (int v = 0; v < 13; v++) begin
      bus.wen = vecs[v].wen; bus.wadd = vecs[v].wadd; bus.wdi = vecs[v].wdi;
      bus.link_en = vecs[v].link_en; bus.link_wdi = vecs[v].link_wdi;
      bus.claim_en = vecs[v].claim_en; bus.claim_add = vecs[v].claim_add;
      bus.clr_req = 1'b0;
      bus.radd1 = vecs[v].ra1; bus.radd2 = vecs[v].ra2; bus.radd_debug = vecs[v].rdbg;
      step();
      chk($sformatf("vec%0d_d1", v), bus.dout1, vecs[v].e1);
      chk($sformatf("vec%0d_d2", v), bus.dout2, vecs[v].e2);
      chk($sformatf("vec%0d_dbg", v), bus.dout_debug, vecs[v].edbg);
      chk($sformatf("vec%0d_r1", v), bus.rdy1, vecs[v].er1);
      chk($sformatf("vec%0d_r2", v), bus.rdy2, vecs[v].er2);
    end

    // Load 1..31 with their index, leave a few claims behind.
    for (int i = 1; i < 32; i++) begin
      idle_inputs();
      bus.wen = 1'b1; bus.wadd = 5'(i); bus.wdi = 32'(i);
      bus.claim_en = (i % 5 == 0); bus.claim_add = 5'(i + 3);
      bus.radd1 = 5'(i); bus.radd2 = 5'(i - 1); bus.radd_debug = 5'(i);
      step();
    end

    // Soft clear with hostile traffic for as long as busy is seen.
    idle_inputs();
    bus.clr_req = 1'b1;
    step();
    busy_cnt = bus.clr_busy ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.clr_busy) break;
      bus.wen = 1'b1; bus.wadd = 5'($urandom_range(1, 31)); bus.wdi = $urandom;
      bus.link_en = 1'b1; bus.link_wdi = $urandom;
      bus.claim_en = 1'b1; bus.claim_add = 5'($urandom_range(1, 31));
      bus.clr_req = 1'($urandom_range(0, 1));
      bus.radd1 = 5'(k); bus.radd2 = 5'(31 - k); bus.radd_debug = 5'(k);
      step();
      if (bus.clr_busy) busy_cnt++;
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);

    for (int a = 0; a < 32; a++) begin
      idle_inputs();
      bus.radd1 = 5'(a); bus.radd2 = 5'(31 - a); bus.radd_debug = 5'(a);
      step();
      chk($sformatf("clr_val%0d", a), bus.dout1, rst_val(a));
      chk($sformatf("clr_rdy%0d", a), bus.rdy1, 1'b1);
    end

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.wen = 1'($urandom_range(0, 1));
      bus.wadd = 5'($urandom_range(0, 31)); bus.wdi = $urandom;
      bus.link_en = ($urandom_range(0, 3) == 0); bus.link_wdi = $urandom;
      bus.claim_en = ($urandom_range(0, 2) == 0); bus.claim_add = 5'($urandom_range(0, 31));
      bus.clr_req = ($urandom_range(0, 59) == 0);
      bus.radd1 = ($urandom_range(0, 1) == 1) ? bus.wadd : 5'($urandom_range(0, 31));
      bus.radd2 = ($urandom_range(0, 1) == 1) ? bus.claim_add : 5'($urandom_range(0, 31));
      bus.radd_debug = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      step();
    end

    // Reset in the middle of a sweep.
    idle_inputs();
    for (int k = 0; k < 40 && m_busy; k++) step();
    chk("pre_abort_idle", bus.clr_busy, 1'b0);
    bus.wen = 1'b1; bus.wadd = 5'd5; bus.wdi = 32'h1234;
    step();
    idle_inputs();
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (10) step();
    chk("abort_busy_before", bus.clr_busy, 1'b1);
    #2 res = 1'b1;
    #1;
    chk_reset_outs("abort");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_outs("abort_hold");
    res = 1'b0;
    bus.radd1 = 5'd28; bus.radd2 = 5'd29; bus.radd_debug = 5'd5;
    step();
    chk("abort_r28", bus.dout1, 32'h10008000);
    chk("abort_r29", bus.dout2, 32'h000000FF);
    chk("abort_r5", bus.dout_debug, 32'h0);
    repeat (3) step();
    chk("abort_no_resume", bus.clr_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the team's 32x32 CPU register file. It provides two registered read ports, a debug read port, a general write port and a dedicated link-register write port for `jal`. It adds same-cycle write-to-read bypass, an optional hard-wired zero register, a per-register pending-write scoreboard for the pipeline's hazard logic, and a sequenced soft-clear that restores reset contents without asserting `res`. It sits between decode (read/claim) and write-back (write) in the pipelined core.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries; ADDR_W >= 5 required
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, and is never pending
- GP_IDX, 28, index loaded with GP_INIT on reset/clear
- GP_INIT, 32'h10008000, reset value of GP_IDX
- SP_IDX, 29, index loaded with SP_INIT on reset/clear
- SP_INIT, 32'h000000FF, reset value of SP_IDX
- LINK_IDX, 31, target of the link write port
- clk  in  1  single clock; all state updates on rising edge
- res  in  1  reset, asynchronous, active-high
- radd1, radd2  in  ADDR_W  read addresses
- dout1, dout2  out  DATA_W  registered read data
- rdy1, rdy2  out  1  registered; 1 = read register has no pending producer
- wen  in  1  general write enable
- wadd  in  ADDR_W  general write address
- wdi  in  DATA_W  general write data
- link_en  in  1  link write enable (writes LINK_IDX)
- link_wdi  in  DATA_W  link data (pc+4, computed upstream)
- claim_en  in  1  mark claim_add pending (producer issued)
- claim_add  in  ADDR_W  register being claimed
- clr_req  in  1  start soft clear
- clr_busy  out  1  soft-clear sequence in progress
- radd_debug  in  ADDR_W  debug read address
- dout_debug  out  DATA_W  registered debug data

## Operation
- Reset (`res`=1, async): every entry is 0 except GP_IDX=GP_INIT and SP_IDX=SP_INIT. All pending bits are 0. dout1/dout2/dout_debug = 0, rdy1/rdy2 = 1, clr_busy = 0, FSM = IDLE.
- Writes:
  - wen writes wdi to wadd; link_en writes link_wdi to LINK_IDX.
  - Both to the same entry in one cycle: the link write wins.
  - Writes to entry 0 are dropped when ZERO_REG=1.
- Scoreboard:
  - claim_en sets pending[claim_add].
  - A write (either port) clears pending for its target.
  - Claim and write to the same entry in one cycle: pending ends set (the claim is the newer producer).
  - Claims to entry 0 are ignored when ZERO_REG=1.
- Reads: on each edge, dout1 is loaded from entry radd1 and rdy1 from !pending[radd1]; port 2 likewise. Bypass (write-first):
  - If a write targets radd1 in the same cycle, dout1 takes the write data (link data if both ports hit).
  - rdy1 takes the post-update pending value for that entry.
- Debug port: dout_debug is loaded every cycle from entry radd_debug, with the same bypass; it has no rdy output.
- Soft-clear FSM:
  - IDLE: clr_req=1 sets the index counter to 0, clears all pending bits, and moves to CLEAR.
  - CLEAR: writes the reset value of entry idx each cycle, then idx+1. After writing idx=DEPTH-1 it returns to IDLE.
  - clr_busy=1 exactly while in CLEAR.
  - In CLEAR, wen/link_en/claim_en/clr_req are ignored, and rdy1/rdy2 load 0. Reads return current array contents with no bypass.
- The counter is ADDR_W+1 bits wide; it must not wrap early.

## Timing
- Read latency is 1 cycle: an address presented before edge N gives data valid after edge N.
- A write at edge N is visible to reads sampled at edge N (bypass) and later.
- Soft clear takes DEPTH+1 cycles in total:
  - 1 cycle IDLE→CLEAR (the edge that samples clr_req),
  - then DEPTH cycles with clr_busy=1.
  - The first accepted write is on the edge after clr_busy falls.
- `res` asserted mid-clear: immediate return to IDLE with reset contents; the sweep is not resumed.

## Test plan
- After reset, read radd1=28, radd2=29 → dout1=32'h10008000, dout2=32'h000000FF, rdy1=rdy2=1; radd_debug=5 → dout_debug=0.
- Write wadd=3, wdi=32'hDEADBEEF with radd1=3 in the same cycle → dout1=32'hDEADBEEF after that edge (bypass); next cycle still 32'hDEADBEEF.
- Write wadd=0, wdi=32'h1234 (ZERO_REG=1), then read 0 → 0. Simultaneous wen to 31 (32'hAAAA) and link_en (32'h0040_0008) → entry 31 = 32'h0040_0008.
- Claim reg 7, then read 7 → rdy1=0. Next cycle, write 7 = 32'h55 and read 7 simultaneously → dout1=32'h55, rdy1=1. Claim and write 7 together → rdy=0 afterwards.
- Load regs 1..31 with their index, then pulse clr_req:
  - clr_busy is high for exactly 32 cycles, and writes/claims during it have no effect.
  - Afterwards reg 28 = 32'h10008000, reg 29 = 32'hFF, all others 0, all rdy = 1.
- Assert res 10 cycles into a soft clear → clr_busy=0 immediately, contents equal the reset values, outputs return to their reset values.
